// File: rtl/cache_repl_init_ctrl.sv
// Per-bank init/flush sequencer: sweeps every line index of the bank into the
// replacement and tag stores after reset and on each accepted flush.
module cache_repl_init_ctrl #(
  parameter int CACHE_SIZE     = 1024,
  parameter int LINE_SIZE      = 64,
  parameter int NUM_BANKS      = 1,
  parameter int NUM_WAYS       = 4,
  parameter int INIT_ON_RESET  = 1,
  parameter int LINES_PER_BANK = CACHE_SIZE / (LINE_SIZE * NUM_BANKS * NUM_WAYS),
  parameter int LINE_SEL_BITS  = (LINES_PER_BANK > 1) ? $clog2(LINES_PER_BANK) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush_valid,
  output logic                     flush_ready,
  input  logic                     pipe_empty,
  output logic                     init_valid,
  output logic [LINE_SEL_BITS-1:0] init_line,
  input  logic                     init_ready,
  output logic                     core_stall,
  output logic                     busy,
  output logic                     done_valid,
  input  logic                     done_ready
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [LINE_SEL_BITS-1:0] LAST_LINE = LINE_SEL_BITS'(LINES_PER_BANK - 1);
  localparam logic [LINE_SEL_BITS-1:0] LINE_ONE  = LINE_SEL_BITS'(1);

  state_e                   state_r;
  state_e                   state_nxt_s;
  logic [LINE_SEL_BITS-1:0] line_ctr_r;
  logic [LINE_SEL_BITS-1:0] line_ctr_nxt_s;
  logic                     beat_s;
  logic                     last_s;

  // init_valid is itself registered, so a beat never depends combinationally on state decode
  assign beat_s    = init_valid & init_ready;
  assign last_s    = (line_ctr_r == LAST_LINE);
  assign init_line = line_ctr_r;

  // Next-state and line counter logic
  always_comb begin
    state_nxt_s    = state_r;
    line_ctr_nxt_s = line_ctr_r;
    case (state_r)
      ST_START: begin
        if (INIT_ON_RESET != 0) begin
          state_nxt_s = ST_INIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_INIT, ST_FLUSH: begin
        if (beat_s) begin
          if (last_s) begin
            line_ctr_nxt_s = '0;
            state_nxt_s    = (state_r == ST_INIT) ? ST_IDLE : ST_DONE;
          end else begin
            line_ctr_nxt_s = line_ctr_r + LINE_ONE;
            state_nxt_s    = state_r;
          end
        end else begin
          line_ctr_nxt_s = line_ctr_r;
          state_nxt_s    = state_r;
        end
      end
      ST_IDLE: begin
        if (flush_valid) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty) begin
          state_nxt_s = ST_FLUSH;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (done_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      default: begin
        state_nxt_s    = ST_START;
        line_ctr_nxt_s = '0;
      end
    endcase
  end

  // State, counter and outputs; outputs are decoded from the next state so they align with state_r
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_START;
      line_ctr_r  <= '0;
      init_valid  <= 1'b0;
      flush_ready <= 1'b0;
      done_valid  <= 1'b0;
      core_stall  <= 1'b1;
      busy        <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      line_ctr_r  <= line_ctr_nxt_s;
      init_valid  <= (state_nxt_s == ST_INIT) || (state_nxt_s == ST_FLUSH);
      flush_ready <= (state_nxt_s == ST_IDLE);
      done_valid  <= (state_nxt_s == ST_DONE);
      core_stall  <= (state_nxt_s != ST_IDLE);
      busy        <= (state_nxt_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cache_repl_init_ctrl.sv
// Randomized bench for cache_repl_init_ctrl: a 4-line init-on-reset unit and a
// 1-line no-init unit, both compared every cycle against a sweep/flush model.
module tb_cache_repl_init_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] flush_valid, flush_ready, pipe_empty, init_valid, init_ready;
  logic [1:0] core_stall, busy, done_valid, done_ready;
  logic [1:0] init_line0;
  logic [0:0] init_line1;

  int n_vec = 0;
  int n_err = 0;

  // Model: pending START, lines remaining in the current sweep, sweep kind, drain, done pending
  bit start_p  [2];
  int lines_left [2];
  bit is_flush [2];
  bit draining [2];
  bit done_p   [2];
  bit did_mid_reset = 1'b0;
  int flushes_done = 0;

  always #5 clk = ~clk;

  cache_repl_init_ctrl dut0 (
    .clk(clk), .reset(reset),
    .flush_valid(flush_valid[0]), .flush_ready(flush_ready[0]),
    .pipe_empty(pipe_empty[0]),
    .init_valid(init_valid[0]), .init_line(init_line0), .init_ready(init_ready[0]),
    .core_stall(core_stall[0]), .busy(busy[0]),
    .done_valid(done_valid[0]), .done_ready(done_ready[0])
  );

  cache_repl_init_ctrl #(.NUM_WAYS(16), .INIT_ON_RESET(0)) dut1 (
    .clk(clk), .reset(reset),
    .flush_valid(flush_valid[1]), .flush_ready(flush_ready[1]),
    .pipe_empty(pipe_empty[1]),
    .init_valid(init_valid[1]), .init_line(init_line1), .init_ready(init_ready[1]),
    .core_stall(core_stall[1]), .busy(busy[1]),
    .done_valid(done_valid[1]), .done_ready(done_ready[1])
  );

  function automatic int lpb(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      start_p[k]    = 1'b1;
      lines_left[k] = 0;
      is_flush[k]   = 1'b0;
      draining[k]   = 1'b0;
      done_p[k]     = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    if (start_p[k]) begin
      start_p[k] = 1'b0;
      if (k == 0) begin
        lines_left[k] = lpb(k);
        is_flush[k]   = 1'b0;
      end
    end else if (lines_left[k] > 0) begin
      if (init_ready[k]) begin
        lines_left[k]--;
        if (lines_left[k] == 0 && is_flush[k]) done_p[k] = 1'b1;
      end
    end else if (draining[k]) begin
      if (pipe_empty[k]) begin
        draining[k]   = 1'b0;
        lines_left[k] = lpb(k);
        is_flush[k]   = 1'b1;
      end
    end else if (done_p[k]) begin
      if (done_ready[k]) begin
        done_p[k] = 1'b0;
        flushes_done++;
      end
    end else if (flush_valid[k]) begin
      draining[k] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit sweeping, idle;
      int exp_line, act_line;
      sweeping = (lines_left[k] > 0);
      idle     = !(start_p[k] || sweeping || draining[k] || done_p[k]);
      exp_line = sweeping ? (lpb(k) - lines_left[k]) : 0;
      act_line = (k == 0) ? int'(init_line0) : int'(init_line1);
      chk($sformatf("u%0d.init_valid", k), int'(init_valid[k]), int'(sweeping));
      chk($sformatf("u%0d.init_line", k), act_line, exp_line);
      chk($sformatf("u%0d.flush_ready", k), int'(flush_ready[k]), int'(idle));
      chk($sformatf("u%0d.core_stall", k), int'(core_stall[k]), int'(!idle));
      chk($sformatf("u%0d.busy", k), int'(busy[k]), int'(!idle));
      chk($sformatf("u%0d.done_valid", k), int'(done_valid[k]), int'(done_p[k]));
    end
  endtask

  // Reset asserted between clock edges: outputs must change without waiting for a clock
  task automatic mid_cycle_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    check_all();
    #2 reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    flush_valid = 2'b11;
    pipe_empty  = 2'b00;
    init_ready  = 2'b11;
    done_ready  = 2'b00;
    model_reset();
    @(negedge clk);
    check_all();
    @(negedge clk);
    check_all();
    #2 reset = 1'b0;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      if (!reset) begin
        model_step(0);
        model_step(1);
      end
      @(negedge clk);
      check_all();
      if (cyc < 30) begin
        // Flush held from reset release; it must only be taken once IDLE is reached
        flush_valid = 2'b11;
        init_ready  = 2'b11;
        pipe_empty  = 2'($urandom_range(0, 3));
        done_ready  = 2'($urandom_range(0, 3));
      end else begin
        for (int k = 0; k < 2; k++) begin
          flush_valid[k] = ($urandom_range(0, 99) < 30);
          init_ready[k]  = ($urandom_range(0, 99) < 65);
          pipe_empty[k]  = ($urandom_range(0, 99) < 40);
          done_ready[k]  = ($urandom_range(0, 99) < 30);
        end
      end
      if (!did_mid_reset && is_flush[0] && lines_left[0] == 2 && cyc > 30) begin
        did_mid_reset = 1'b1;
        mid_cycle_reset();
      end else if (cyc > 100 && $urandom_range(0, 399) == 0) begin
        mid_cycle_reset();
      end
    end

    chk("mid_flush_reset_hit", int'(did_mid_reset), 1);
    chk("flushes_completed", int'(flushes_done > 10), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
